// File: rtl/bin_dilate_3x3.sv
// bin_dilate_3x3: 3x3 binary dilation of a streamed 1-bit image.
// Each output pixel is the OR of its 3x3 neighbourhood. Pixels outside the
// image count as 0. Output row r-1 is produced while input row r streams in.
// The last output row is emitted by a flush pass that replays the line
// buffers with an all-zero bottom row. The output is delayed 2 cycles from
// the input pixel that completes its window.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   per_img_vsync/href/bit     input frame valid, pixel valid, binary pixel
//   post_img_vsync/href/bit    dilated frame valid, pixel valid, pixel
module bin_dilate_3x3 #(
    parameter int IMG_H_DISP = 512,
    parameter int IMG_V_DISP = 512
) (
    input  logic clk,
    input  logic rst_n,
    input  logic per_img_vsync,
    input  logic per_img_href,
    input  logic per_img_bit,
    output logic post_img_vsync,
    output logic post_img_href,
    output logic post_img_bit
);

    localparam int COL_W  = (IMG_H_DISP > 1) ? $clog2(IMG_H_DISP) : 1;
    localparam int ROW_W  = $clog2(IMG_V_DISP + 1);
    localparam int FCNT_W = $clog2(IMG_H_DISP + 5);

    localparam logic [COL_W-1:0]  COL_LAST    = COL_W'(IMG_H_DISP - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST    = ROW_W'(IMG_V_DISP - 1);
    localparam logic [FCNT_W-1:0] FLUSH_FIRST = FCNT_W'(4);
    localparam logic [FCNT_W-1:0] FLUSH_LAST  = FCNT_W'(IMG_H_DISP + 3);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    state_t state_r, state_nxt_s;

    logic vsync_d_r, href_d_r;
    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_cnt_r;
    logic [FCNT_W-1:0] flush_cnt_r;

    // lb0 holds input row r-2 and lb1 row r-1 relative to the streaming row r
    logic lb0_r [IMG_H_DISP];
    logic lb1_r [IMG_H_DISP];

    // Window columns: c2 newest, c1 centre, c0 oldest; bit order {top, mid, bot}
    logic [2:0] c0_r, c1_r, c2_r;
    logic v2_r, v1_r;
    logic e2_r, e1_r, e0_r;
    logic post_vsync_r, post_href_r, post_bit_r;

    logic vsync_rise_s, vsync_fall_s, href_fall_s;
    logic stream_valid_s, flush_valid_s, src_valid_s, out_valid_s;
    logic row_done_s, abort_s, flush_end_s;
    logic top_s, mid_s, bot_s;
    logic [2:0] col_in_s;

    // Edge detection, source-valid qualification and window column assembly
    always_comb begin
        vsync_rise_s   = per_img_vsync & ~vsync_d_r;
        vsync_fall_s   = ~per_img_vsync & vsync_d_r;
        href_fall_s    = ~per_img_href & href_d_r;
        stream_valid_s = (state_r == ST_STREAM) & per_img_href;
        flush_valid_s  = (state_r == ST_FLUSH) & (flush_cnt_r >= FLUSH_FIRST)
                         & (flush_cnt_r <= FLUSH_LAST);
        src_valid_s    = stream_valid_s | flush_valid_s;
        flush_end_s    = flush_valid_s & (flush_cnt_r == FLUSH_LAST);
        row_done_s     = (state_r == ST_STREAM) & href_fall_s & (row_cnt_r == ROW_LAST);
        // A row that completes on the same cycle vsync drops still gets flushed
        abort_s        = (state_r == ST_STREAM) & vsync_fall_s & ~row_done_s;
        // Input row 0 only fills the buffers; no output row precedes it
        out_valid_s    = src_valid_s & (flush_valid_s | (row_cnt_r != {ROW_W{1'b0}}));
        // Rows 0 and 1 have no valid row r-2 in lb0: top padding
        top_s          = (row_cnt_r > ROW_W'(1)) ? lb0_r[col_r] : 1'b0;
        mid_s          = lb1_r[col_r];
        // During flush the bottom row is the zero padding below the image
        bot_s          = stream_valid_s ? per_img_bit : 1'b0;
        // A zero column enters whenever there is no source pixel: left/right padding
        col_in_s       = src_valid_s ? {top_s, mid_s, bot_s} : 3'b000;
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (vsync_rise_s) state_nxt_s = ST_STREAM;
                else              state_nxt_s = ST_IDLE;
            end
            ST_STREAM: begin
                if (row_done_s)   state_nxt_s = ST_FLUSH;
                else if (abort_s) state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_STREAM;
            end
            ST_FLUSH: begin
                if (flush_end_s)  state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_FLUSH;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Line buffers: shift row r-1 into lb0, store the new pixel in lb1
    always_ff @(posedge clk) begin
        if (stream_valid_s) begin
            lb0_r[col_r] <= lb1_r[col_r];
            lb1_r[col_r] <= per_img_bit;
        end
    end

    // State, counters, window pipeline and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            // Track vsync through reset so a frame already in progress at
            // release is not mistaken for a new one
            vsync_d_r    <= per_img_vsync;
            href_d_r     <= 1'b0;
            col_r        <= {COL_W{1'b0}};
            row_cnt_r    <= {ROW_W{1'b0}};
            flush_cnt_r  <= {FCNT_W{1'b0}};
            c0_r         <= 3'b000;
            c1_r         <= 3'b000;
            c2_r         <= 3'b000;
            v2_r         <= 1'b0;
            v1_r         <= 1'b0;
            e2_r         <= 1'b0;
            e1_r         <= 1'b0;
            e0_r         <= 1'b0;
            post_vsync_r <= 1'b0;
            post_href_r  <= 1'b0;
            post_bit_r   <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            vsync_d_r <= per_img_vsync;
            href_d_r  <= per_img_href;

            if (state_r == ST_IDLE) begin
                col_r       <= {COL_W{1'b0}};
                row_cnt_r   <= {ROW_W{1'b0}};
                flush_cnt_r <= {FCNT_W{1'b0}};
            end else begin
                if (state_r == ST_STREAM && href_fall_s) begin
                    row_cnt_r <= row_cnt_r + ROW_W'(1);
                    col_r     <= {COL_W{1'b0}};
                end else if (src_valid_s) begin
                    col_r <= (col_r == COL_LAST) ? {COL_W{1'b0}} : col_r + COL_W'(1);
                end else begin
                    col_r <= col_r;
                end
                if (row_done_s)                flush_cnt_r <= FCNT_W'(1);
                else if (state_r == ST_FLUSH)  flush_cnt_r <= flush_cnt_r + FCNT_W'(1);
                else                           flush_cnt_r <= {FCNT_W{1'b0}};
            end

            c2_r <= col_in_s;
            c1_r <= c2_r;
            c0_r <= c1_r;

            if (abort_s) begin
                v2_r         <= 1'b0;
                v1_r         <= 1'b0;
                e2_r         <= 1'b0;
                e1_r         <= 1'b0;
                e0_r         <= 1'b0;
                post_vsync_r <= 1'b0;
                post_href_r  <= 1'b0;
                post_bit_r   <= 1'b0;
            end else begin
                v2_r        <= out_valid_s;
                v1_r        <= v2_r;
                // e0 is high together with the last post_href of the frame
                e2_r        <= flush_end_s;
                e1_r        <= e2_r;
                e0_r        <= e1_r;
                post_href_r <= v1_r;
                post_bit_r  <= v1_r & (|{c0_r, c1_r, c2_r});
                if (state_r == ST_IDLE && vsync_rise_s) post_vsync_r <= 1'b1;
                else if (e0_r)                         post_vsync_r <= 1'b0;
                else                                   post_vsync_r <= post_vsync_r;
            end
        end
    end

    assign post_img_vsync = post_vsync_r;
    assign post_img_href  = post_href_r;
    assign post_img_bit   = post_bit_r;

endmodule
